spiflash_rdctl: RTL

//  Synthesizable SPI flash read controller: the SPI master side for a 24-bit-address serial NOR flash.

---
 rtl/spiflash_pkg.sv | 29 ++
 rtl/spiflash_shift.sv | 84 ++++++++
 rtl/spiflash_rdctl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/spiflash_pkg.sv
// Shared opcodes, phase lengths and FSM encoding for the SPI NOR flash read controller.
package spiflash_pkg;

    localparam logic [7:0] CMD_PWRUP = 8'hAB;
    localparam logic [7:0] CMD_READ  = 8'h03;

    localparam logic [5:0] CMD_BITS  = 6'd8;
    localparam logic [5:0] ADDR_BITS = 6'd24;
    localparam logic [5:0] DATA_BITS = 6'd32;

    typedef enum logic [2:0] {
        PWRUP,
        PWAIT,
        IDLE,
        CSGAP,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_t;

    // Word address (byte address bits [23:2]); wraps naturally like the flash's own counter.
    typedef logic [21:0] waddr_t;

    function automatic waddr_t next_waddr(input waddr_t a);
        return a + waddr_t'(1);
    endfunction

endpackage

// File: rtl/spiflash_shift.sv
// Mode-0 SPI bit engine: divides clk into SCLK half-periods and shifts up to 32 bits MSB first.
module spiflash_shift #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [5:0]  nbits,
    input  logic [31:0] tx,
    input  logic        miso,
    output logic        done,
    output logic        busy,
    output logic [31:0] rx,
    output logic        sclk,
    output logic        mosi
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_reg;
    logic [5:0]    bits_left_reg;
    logic [31:0]   tx_reg;
    logic [31:0]   rx_reg;
    logic          busy_reg;
    logic          sclk_reg;
    logic          mosi_reg;

    logic [5:0]    align_sh;
    logic [31:0]   tx_aligned;
    logic          half_end;

    always_comb begin
        align_sh   = 6'd32 - nbits;
        tx_aligned = tx << align_sh;
        half_end   = busy_reg && (div_cnt_reg == DIV_LAST);
        // Asserted in the final high half-period so a follow-on start can load without a gap.
        done       = half_end && sclk_reg && (bits_left_reg == 6'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_reg   <= '0;
            bits_left_reg <= '0;
            tx_reg        <= '0;
            rx_reg        <= '0;
            busy_reg      <= 1'b0;
            sclk_reg      <= 1'b0;
            mosi_reg      <= 1'b0;
        end else if (start) begin
            busy_reg      <= 1'b1;
            sclk_reg      <= 1'b0;
            div_cnt_reg   <= '0;
            mosi_reg      <= tx_aligned[31];
            tx_reg        <= {tx_aligned[30:0], 1'b0};
            bits_left_reg <= nbits - 6'd1;
        end else if (busy_reg) begin
            if (half_end) begin
                div_cnt_reg <= '0;
                if (!sclk_reg) begin
                    sclk_reg <= 1'b1;
                    rx_reg   <= {rx_reg[30:0], miso};
                end else begin
                    sclk_reg <= 1'b0;
                    if (bits_left_reg == 6'd0) begin
                        busy_reg <= 1'b0;
                        mosi_reg <= 1'b0;
                    end else begin
                        mosi_reg      <= tx_reg[31];
                        tx_reg        <= {tx_reg[30:0], 1'b0};
                        bits_left_reg <= bits_left_reg - 6'd1;
                    end
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + DW'(1);
            end
        end
    end

    assign busy = busy_reg;
    assign rx   = rx_reg;
    assign sclk = sclk_reg;
    assign mosi = mosi_reg;

endmodule

// File: rtl/spiflash_rdctl.sv
// SPI NOR flash read controller: power-up, 0x03 reads and CS-low continuation for sequential words.
module spiflash_rdctl #(
    parameter int CLK_DIV      = 1,
    parameter int PWRUP_CYCLES = 16,
    parameter int CS_IDLE      = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic [23:0] addr,
    output logic [31:0] rdata,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    import spiflash_pkg::*;

    localparam logic [15:0] PWAIT_LAST = 16'((PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0);
    localparam logic [15:0] GAP_MIN    = 16'(CS_IDLE);

    state_t      state_reg, state_next;
    waddr_t      addr_reg;
    waddr_t      nxt_addr_reg;
    logic        cs_reg;
    logic [15:0] gap_cnt_reg;
    logic [31:0] rdata_reg;
    logic [31:0] rx_le;

    logic        sh_start;
    logic [5:0]  sh_nbits;
    logic [31:0] sh_tx;
    logic        sh_done;
    logic        sh_busy;
    logic [31:0] sh_rx;

    logic        addr_load;
    logic        cs_raise;
    logic        gap_met;
    logic        pwait_met;
    logic        is_seq;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    spiflash_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk    (clk),
        .resetn (resetn),
        .start  (sh_start),
        .nbits  (sh_nbits),
        .tx     (sh_tx),
        .miso   (spi_miso),
        .done   (sh_done),
        .busy   (sh_busy),
        .rx     (sh_rx),
        .sclk   (spi_sclk),
        .mosi   (spi_mosi)
    );

    // First byte on the wire is the lowest-addressed byte and lands in rdata[7:0].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bswap
            assign rx_le[8*gi +: 8] = sh_rx[31-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        sh_start   = 1'b0;
        sh_nbits   = CMD_BITS;
        sh_tx      = 32'd0;
        addr_load  = 1'b0;
        cs_raise   = 1'b0;
        gap_met    = (gap_cnt_reg >= GAP_MIN);
        pwait_met  = (gap_cnt_reg >= PWAIT_LAST);
        is_seq     = (addr[23:2] == nxt_addr_reg);

        case (state_reg)
            PWRUP: begin
                sh_tx = {24'd0, CMD_PWRUP};
                if (!sh_busy) begin
                    sh_start = 1'b1;
                end else if (sh_done) begin
                    cs_raise   = 1'b1;
                    state_next = PWAIT;
                end
            end
            PWAIT: begin
                if (pwait_met) state_next = IDLE;
            end
            IDLE: begin
                if (valid) begin
                    addr_load = 1'b1;
                    if (!cs_reg) begin
                        if (is_seq) begin
                            state_next = DATA;
                        end else begin
                            cs_raise   = 1'b1;
                            state_next = CSGAP;
                        end
                    end else if (gap_met) begin
                        state_next = CMD;
                    end else begin
                        state_next = CSGAP;
                    end
                end
            end
            CSGAP: begin
                if (gap_met) state_next = CMD;
            end
            CMD: begin
                sh_tx = {24'd0, CMD_READ};
                if (!sh_busy) begin
                    sh_start = 1'b1;
                end else if (sh_done) begin
                    sh_start   = 1'b1;
                    sh_nbits   = ADDR_BITS;
                    sh_tx      = {8'd0, addr_reg, 2'b00};
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (sh_done) begin
                    sh_start   = 1'b1;
                    sh_nbits   = DATA_BITS;
                    state_next = DATA;
                end
            end
            DATA: begin
                sh_nbits = DATA_BITS;
                if (!sh_busy) begin
                    sh_start = 1'b1;
                end else if (sh_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= PWRUP;
            addr_reg     <= '0;
            nxt_addr_reg <= '0;
            cs_reg       <= 1'b1;
            gap_cnt_reg  <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (addr_load) addr_reg <= addr[23:2];
            // CS falls together with the first bit of any shift; it rises only on explicit request.
            if (sh_start) begin
                cs_reg <= 1'b0;
            end else if (cs_raise) begin
                cs_reg <= 1'b1;
            end
            if (cs_raise) begin
                gap_cnt_reg <= '0;
            end else if (cs_reg && (gap_cnt_reg != 16'hFFFF)) begin
                gap_cnt_reg <= gap_cnt_reg + 16'd1;
            end
            if ((state_reg == DATA) && sh_done) begin
                rdata_reg    <= rx_le;
                nxt_addr_reg <= next_waddr(addr_reg);
            end
        end
    end

    assign ready  = (state_reg == DONE);
    assign rdata  = rdata_reg;
    assign spi_cs = cs_reg;

endmodule
